// File: rtl/reset_sequencer_pkg.sv
// Shared state encoding, default sequencing constants and a counter-width helper
// for the reset release sequencer.
package reset_sequencer_pkg;

    localparam int DEF_NUM_STAGES  = 4;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_ACK_TIMEOUT = 1024;
    localparam int DEF_MAX_RETRY   = 3;
    localparam int RETRY_W         = 2;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_RELEASE,
        ST_WAIT_ACK,
        ST_DONE,
        ST_ERROR
    } seq_state_t;

    // Ceiling log2, never below 1 so it can size any counter or index directly.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/reset_sequencer_lock_debounce.sv
// PLL lock 2-flop synchronizer plus continuous-high stability counter; lock_sync lags
// pll_locked by 2 cycles, lock_stable rises HOLD_CYCLES after that; no backpressure.
module lock_debounce
    import reset_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic clk,
    input  logic sync_rst,
    input  logic pll_locked,
    input  logic hold_clr,
    output logic lock_sync,
    output logic lock_stable
);

    localparam int HW = clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    logic          lock_meta;
    logic [HW-1:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
            // Saturates at HOLD_CYCLES; any dropout or a sequencer restart starts over.
            if (hold_clr || !lock_sync) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

    assign lock_stable = (hold_cnt == HOLD_MAX);

endmodule

// File: rtl/reset_sequencer.sv
// Ordered per-stage reset release gated on stable PLL lock and per-stage ready acks;
// one release per RELEASE cycle, waits on stage_ack with bounded timeout and retries.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_STAGES  = DEF_NUM_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
    input  logic                  clk,
    input  logic                  sync_rst,
    input  logic                  pll_locked,
    input  logic                  soft_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  seq_done,
    output logic                  seq_error,
    output logic [RETRY_W-1:0]    retry_cnt
);

    localparam int KW = clog2(NUM_STAGES);
    localparam int TW = clog2(ACK_TIMEOUT + 1);
    localparam logic [KW-1:0] LAST_K   = KW'(NUM_STAGES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    seq_state_t            state, state_nxt;
    logic [KW-1:0]         k, k_nxt;
    logic [TW-1:0]         tmo_cnt, tmo_cnt_nxt;
    logic [RETRY_W-1:0]    retry_nxt, retry_inc;
    logic [NUM_STAGES-1:0] stage_rst_nxt;
    logic                  done_nxt, error_nxt;
    logic                  hold_clr;
    logic                  lock_sync, lock_stable;
    logic                  lock_lost;

    lock_debounce #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_lock_debounce (
        .clk         (clk),
        .sync_rst    (sync_rst),
        .pll_locked  (pll_locked),
        .hold_clr    (hold_clr),
        .lock_sync   (lock_sync),
        .lock_stable (lock_stable)
    );

    assign lock_lost = !lock_sync &&
                       (state == ST_RELEASE || state == ST_WAIT_ACK || state == ST_DONE);
    assign retry_inc = (&retry_cnt) ? retry_cnt : retry_cnt + RETRY_W'(1);

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state     <= ST_WAIT_LOCK;
            k         <= '0;
            tmo_cnt   <= '0;
            retry_cnt <= '0;
            stage_rst <= '1;
            seq_done  <= 1'b0;
            seq_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            retry_cnt <= retry_nxt;
            stage_rst <= stage_rst_nxt;
            seq_done  <= done_nxt;
            seq_error <= error_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        k_nxt         = k;
        tmo_cnt_nxt   = tmo_cnt;
        retry_nxt     = retry_cnt;
        stage_rst_nxt = stage_rst;
        done_nxt      = seq_done;
        error_nxt     = seq_error;
        hold_clr      = 1'b0;

        if (state == ST_ERROR) begin
            stage_rst_nxt = '1;
            done_nxt      = 1'b0;
            error_nxt     = 1'b1;
        end else if (lock_lost || soft_rst_req) begin
            // Lock loss outranks a soft request, so only a pure soft request clears retries.
            state_nxt     = ST_WAIT_LOCK;
            k_nxt         = '0;
            tmo_cnt_nxt   = '0;
            stage_rst_nxt = '1;
            done_nxt      = 1'b0;
            if (!lock_lost) begin
                retry_nxt = '0;
                hold_clr  = 1'b1;
            end
        end else begin
            case (state)
                ST_WAIT_LOCK: begin
                    if (lock_stable) begin
                        state_nxt = ST_RELEASE;
                        k_nxt     = '0;
                    end
                end
                ST_RELEASE: begin
                    stage_rst_nxt[k] = 1'b0;
                    tmo_cnt_nxt      = '0;
                    state_nxt        = ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (stage_ack[k]) begin
                        if (k == LAST_K) begin
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            k_nxt     = k + KW'(1);
                            state_nxt = ST_RELEASE;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        stage_rst_nxt = '1;
                        k_nxt         = '0;
                        tmo_cnt_nxt   = '0;
                        retry_nxt     = retry_inc;
                        hold_clr      = 1'b1;
                        if (int'(retry_inc) >= MAX_RETRY) begin
                            state_nxt = ST_ERROR;
                            error_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_WAIT_LOCK;
                        end
                    end else begin
                        tmo_cnt_nxt = tmo_cnt + TW'(1);
                    end
                end
                ST_DONE: begin
                    done_nxt = 1'b1;
                end
                default: begin
                    state_nxt = ST_WAIT_LOCK;
                end
            endcase
        end
    end

endmodule
